// File: rtl/tl_ul_pkg.sv
// TileLink-UL shared definitions: opcodes, field widths, beat layouts and helpers
// for the A/D channel buffer.
package tl_ul_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned A_PARAM_W = 3;
  localparam int unsigned D_PARAM_W = 2;
  localparam int unsigned SIZE_W    = 3;
  localparam int unsigned SINK_W    = 1;

  localparam logic [OPCODE_W-1:0] A_PUT_FULL_DATA    = 3'd0;
  localparam logic [OPCODE_W-1:0] A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [OPCODE_W-1:0] A_GET              = 3'd4;
  localparam logic [OPCODE_W-1:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [OPCODE_W-1:0] D_ACCESS_ACK_DATA  = 3'd1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_SRC_W  = 1;

  function automatic int unsigned a_w(input int unsigned addr_w, input int unsigned data_w,
                                      input int unsigned src_w);
    return OPCODE_W + A_PARAM_W + SIZE_W + src_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  function automatic int unsigned d_w(input int unsigned data_w, input int unsigned src_w);
    return OPCODE_W + D_PARAM_W + SIZE_W + src_w + SINK_W + 1 + data_w + 1;
  endfunction

  // Occupancy counter width; a wire-through channel still gets a 1-bit (tied 0) port.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [OPCODE_W-1:0]     opcode;
    logic [A_PARAM_W-1:0]    param;
    logic [SIZE_W-1:0]       size;
    logic [DEF_SRC_W-1:0]    source;
    logic [DEF_ADDR_W-1:0]   address;
    logic [DEF_DATA_W/8-1:0] mask;
    logic [DEF_DATA_W-1:0]   data;
    logic                    corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [D_PARAM_W-1:0]  param;
    logic [SIZE_W-1:0]     size;
    logic [DEF_SRC_W-1:0]  source;
    logic [SINK_W-1:0]     sink;
    logic                  denied;
    logic [DEF_DATA_W-1:0] data;
    logic                  corrupt;
  } tl_d_t;

  localparam int unsigned DEF_A_W = a_w(DEF_ADDR_W, DEF_DATA_W, DEF_SRC_W);
  localparam int unsigned DEF_D_W = d_w(DEF_DATA_W, DEF_SRC_W);

  function automatic logic [DEF_A_W-1:0] pack_a(input tl_a_t a);
    return DEF_A_W'(a);
  endfunction

  function automatic tl_a_t unpack_a(input logic [DEF_A_W-1:0] bits);
    return tl_a_t'(bits);
  endfunction

  function automatic logic [DEF_D_W-1:0] pack_d(input tl_d_t d);
    return DEF_D_W'(d);
  endfunction

  function automatic tl_d_t unpack_d(input logic [DEF_D_W-1:0] bits);
    return tl_d_t'(bits);
  endfunction

endpackage

// File: rtl/tl_ul_fifo.sv
// In-order valid/ready queue; DEPTH=0 degenerates to a wire-through, otherwise the
// output is always driven from storage so there is no in->out combinational path.
module tl_ul_fifo
  import tl_ul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_bits,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_bits,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
    assign out_bits       = in_bits;
    assign count          = '0;
  end else begin : g_queue
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (cnt < CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_bits  = mem[rd_ptr];
    assign count     = cnt;

    always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_bits;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      cnt <= cnt + CNT_W'(1);
        else if (pop && !push) cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL A/D channel buffer: one independent queue per direction, each sized
// separately (0 = wire-through).
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRC_W   = 1,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  localparam int unsigned A_W    = a_w(ADDR_W, DATA_W, SRC_W),
  localparam int unsigned D_W    = d_w(DATA_W, SRC_W)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        a_in_valid,
  output logic                        a_in_ready,
  input  logic [A_W-1:0]              a_in_bits,
  output logic                        a_out_valid,
  input  logic                        a_out_ready,
  output logic [A_W-1:0]              a_out_bits,
  input  logic                        d_in_valid,
  output logic                        d_in_ready,
  input  logic [D_W-1:0]              d_in_bits,
  output logic                        d_out_valid,
  input  logic                        d_out_ready,
  output logic [D_W-1:0]              d_out_bits,
  output logic [cnt_w(A_DEPTH)-1:0]   a_count,
  output logic [cnt_w(D_DEPTH)-1:0]   d_count
);

  tl_ul_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bits   (a_in_bits),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_bits  (a_out_bits),
    .count     (a_count)
  );

  tl_ul_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_bits   (d_in_bits),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_bits  (d_out_bits),
    .count     (d_count)
  );

endmodule

// File: doc/tl_ul_buffer.md
TL_UL_BUFFER -- requirements
Module: tl_ul_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: A-channel address width.
REQ-002 SHALL have parameter DATA_W, default 32: A/D data width; mask width is DATA_W/8.
REQ-003 SHALL have parameter SRC_W, default 1: source-ID width on both channels.
REQ-004 SHALL have parameter A_DEPTH, default 2: A-channel queue entries; 0 = wire-through.
REQ-005 SHALL have parameter D_DEPTH, default 2: D-channel queue entries; 0 = wire-through.
REQ-006 SHALL have port clock, input, 1: sole clock, all state on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port a_in_valid, input, 1: upstream A beat valid.
REQ-009 SHALL have port a_in_ready, output, 1: A beat accepted when valid&ready.
REQ-010 SHALL have port a_in_bits, input, A_W: packed A beat {opcode[2:0], param[2:0], size[2:0], source, address, mask, data, corrupt}.
REQ-011 SHALL have port a_out_valid, output, 1: downstream A beat valid.
REQ-012 SHALL have port a_out_ready, input, 1: downstream accepts A beat.
REQ-013 SHALL have port a_out_bits, output, A_W: packed A beat, same layout.
REQ-014 SHALL have port d_in_valid, input, 1: downstream D beat valid.
REQ-015 SHALL have port d_in_ready, output, 1: D beat accepted when valid&ready.
REQ-016 SHALL have port d_in_bits, input, D_W: packed D beat {opcode[2:0], param[1:0], size[2:0], source, sink, denied, data, corrupt}.
REQ-017 SHALL have port d_out_valid, output, 1: upstream D beat valid.
REQ-018 SHALL have port d_out_ready, input, 1: upstream accepts D beat.
REQ-019 SHALL have port d_out_bits, output, D_W: packed D beat, same layout.
REQ-020 SHALL have port a_count, output, clog2(A_DEPTH+1): A entries held.
REQ-021 SHALL have port d_count, output, clog2(D_DEPTH+1): D entries held.

Function
REQ-022 Depth 0 channel SHALL be pure wire-through (out_valid=in_valid, in_ready=out_ready, bits equal), count tied 0.
REQ-023 Depth N>=1 channel SHALL be an N-entry in-order FIFO; bits never modified, reordered, duplicated or dropped.
REQ-024 in_ready SHALL equal (count < N); no enqueue while full even if out_ready=1 that cycle.
REQ-025 out_valid SHALL equal (count != 0); out_bits SHALL be the head entry from storage, no combinational in->out path.
REQ-026 Latency: beat accepted in cycle t into empty queue SHALL appear on out_valid in cycle t+1.
REQ-027 Enqueue only: count+1; dequeue only: count-1; both same cycle: count unchanged, both pointers advance.
REQ-028 Pointers SHALL wrap N-1 -> 0, correct for non-power-of-two N.
REQ-029 Once out_valid=1, out_valid and out_bits SHALL hold until out_ready=1.
REQ-030 A and D channels SHALL be fully independent; a stall on one never affects the other.
REQ-031 Full-throughput: with N>=2 and out_ready held 1, one beat per cycle SHALL sustain.

Reset
REQ-032 Reset assertion SHALL asynchronously clear pointers and counts: a_count=d_count=0, a_out_valid=d_out_valid=0, a_in_ready=d_in_ready=1 (depth>=1).
REQ-033 Reset mid-operation SHALL discard all held beats; storage arrays SHALL NOT be reset.

Structure
REQ-034 Package tl_ul_pkg SHALL hold opcode constants, A/D field widths, A_W/D_W functions and pack/unpack helpers.
REQ-035 One sub-module tl_ul_fifo (parametrised WIDTH, DEPTH) SHALL be instantiated once per channel.

Verification
REQ-036 A_DEPTH=2: send Get addr 0x1000, 0x1004, 0x1008 with a_out_ready=0 -> first two accepted, a_count=2, a_in_ready=0 on third.
REQ-037 D_DEPTH=3: 7 AccessAckData beats data 0..6, random d_out_ready -> output order 0..6, no loss/duplicate, pointer wraps observed.
REQ-038 A_DEPTH=2 full, a_in_valid=1, a_out_ready=1 same cycle -> dequeue only, a_count 2->1, no enqueue.
REQ-039 A_DEPTH=2 count=1, enqueue+dequeue same cycle -> a_count stays 1, next out_bits is new beat.
REQ-040 Reset asserted with a_count=2, d_count=1 -> same cycle all valids 0, counts 0; after release first new beat out at t+1.
REQ-041 A_DEPTH=0, D_DEPTH=0 -> outputs equal inputs combinationally every cycle, counts 0.
